// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared types and constants for the pipeline hazard controller:
//   mem_state_t      - memory-wait FSM states (IDLE, MEM_WAIT, ERROR)
//   fwd_sel_t        - operand forward select (register file / W / M)
//   RESULT_SRC_LOAD  - ResultSrc encoding that marks a load
//   fwd_select()     - priority encoder for the forward mux select
// ---------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERROR    = 2'b10
  } mem_state_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // The Memory stage holds the younger result, so it wins over Writeback.
  function automatic fwd_sel_t fwd_select(input logic hit_m, input logic hit_w);
    if (hit_m)      return FWD_M;
    else if (hit_w) return FWD_W;
    else            return FWD_REG;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_mem_wait_fsm.sv
// ---------------------------------------------------------------------------
// mem_wait_fsm
// Tracks outstanding memory accesses in the Memory stage and raises a sticky
// timeout error when memory stays unready for too long.
//   clk, rst        - clock, synchronous active-high reset
//   i_mem_req       - Memory stage holds a load or store
//   i_mem_ready     - memory completes the access this cycle
//   o_mem_stall     - stall request (waiting, or permanently in ERROR)
//   o_mem_timeout   - sticky timeout flag (registered)
//   o_state         - current FSM state, exposed for debug/checkers
// Parameter MEM_TIMEOUT: wait cycles allowed before ERROR; 0 disables.
// FSM written as state register / next-state comb / output comb.
// ---------------------------------------------------------------------------
module mem_wait_fsm
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_mem_req,
  input  logic       i_mem_ready,
  output logic       o_mem_stall,
  output logic       o_mem_timeout,
  output mem_state_t o_state
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  mem_state_t       r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_mem_timeout;

  mem_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_timeout_nxt;

  // r_wait_cnt holds the number of completed wait cycles. It saturates so
  // that a disabled timeout can wait forever without wrapping.
  assign w_cnt_inc = (&r_wait_cnt) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_cnt_nxt;
      r_mem_timeout <= w_timeout_nxt;
    end
  end

  // Next-state logic. The timeout fires on the edge where the counter
  // becomes MEM_TIMEOUT, so MemTimeout is visible the following cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_wait_cnt;
    w_timeout_nxt = r_mem_timeout;
    case (r_state)
      ST_IDLE: begin
        if (i_mem_req && !i_mem_ready) begin
          w_cnt_nxt = CNT_W'(1);
          if (TIMEOUT_EN && (CNT_W'(1) == TIMEOUT_VAL)) begin
            w_state_nxt   = ST_ERROR;
            w_timeout_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_MEM_WAIT;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (i_mem_ready) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (TIMEOUT_EN && (w_cnt_inc == TIMEOUT_VAL)) begin
            w_state_nxt   = ST_ERROR;
            w_timeout_nxt = 1'b1;
          end
        end
      end
      ST_ERROR: begin
        w_state_nxt = ST_ERROR;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs. A same-cycle ready never stalls; ERROR stalls regardless of
  // inputs and releases as soon as reset returns the state to IDLE.
  always_comb begin
    o_mem_stall   = (i_mem_req && !i_mem_ready) || (r_state == ST_ERROR);
    o_mem_timeout = r_mem_timeout;
    o_state       = r_state;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use stall,
// branch flush and memory-wait stall with timeout, plus optional perf
// counters.
//   Inputs : clk, rst (sync, active-high), stage register indices
//            (Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW), RegWriteE/M/W,
//            ResultSrcE, PCSrcE, MemReqM, MemReadyM
//   Outputs: ForwardAE/BE, StallFetch/Decode/Execute/Memory,
//            FlushDecode/Execute/Writeback, MemTimeout,
//            LoadUseCnt, MemStallCnt, FlushCnt, o_dbg_state (FSM state)
// Macro HAZARD_PERF_CNT_EN: when defined the performance counters are
// built; otherwise the counter ports are driven with zero.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_FILE_ADDRESS_WIDTH = 5,
  parameter int MEM_TIMEOUT            = 64,
  parameter int PERF_CNT_WIDTH         = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs1D,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs2D,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs1E,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs2E,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdE,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdM,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdW,
  input  logic                              RegWriteE,
  input  logic                              RegWriteM,
  input  logic                              RegWriteW,
  input  logic [1:0]                        ResultSrcE,
  input  logic                              PCSrcE,
  input  logic                              MemReqM,
  input  logic                              MemReadyM,
  output logic [1:0]                        ForwardAE,
  output logic [1:0]                        ForwardBE,
  output logic                              StallFetch,
  output logic                              StallDecode,
  output logic                              StallExecute,
  output logic                              StallMemory,
  output logic                              FlushDecode,
  output logic                              FlushExecute,
  output logic                              FlushWriteback,
  output logic                              MemTimeout,
  output logic [PERF_CNT_WIDTH-1:0]         LoadUseCnt,
  output logic [PERF_CNT_WIDTH-1:0]         MemStallCnt,
  output logic [PERF_CNT_WIDTH-1:0]         FlushCnt,
  output logic [1:0]                        o_dbg_state
);

  logic       w_mem_stall;
  logic       w_load_use;
  logic       w_flush_decode;
  mem_state_t w_state;
  fwd_sel_t   w_fwd_a;
  fwd_sel_t   w_fwd_b;

  // RegWriteE is part of the stage interface but the load-use check keys
  // off ResultSrcE alone; fold it in here so it is visibly consumed.
  logic w_unused;
  assign w_unused = RegWriteE;

  mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_fsm (
    .clk          (clk),
    .rst          (rst),
    .i_mem_req    (MemReqM),
    .i_mem_ready  (MemReadyM),
    .o_mem_stall  (w_mem_stall),
    .o_mem_timeout(MemTimeout),
    .o_state      (w_state)
  );

  assign o_dbg_state = w_state;

  // Forwarding: register x0 is never forwarded.
  assign w_fwd_a = fwd_select(RegWriteM && (RdM != '0) && (RdM == Rs1E),
                              RegWriteW && (RdW != '0) && (RdW == Rs1E));
  assign w_fwd_b = fwd_select(RegWriteM && (RdM != '0) && (RdM == Rs2E),
                              RegWriteW && (RdW != '0) && (RdW == Rs2E));
  assign ForwardAE = w_fwd_a;
  assign ForwardBE = w_fwd_b;

  assign w_load_use = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

  // Memory stall freezes every stage and bubbles Writeback. A branch
  // resolved during the stall is not lost: Execute is held, so PCSrcE is
  // still asserted once the stall drops and the flush happens then.
  // A taken branch squashes the load-use victim, so no stall is needed.
  assign w_flush_decode = !w_mem_stall && PCSrcE;

  assign StallFetch     = w_mem_stall || (w_load_use && !PCSrcE);
  assign StallDecode    = w_mem_stall || (w_load_use && !PCSrcE);
  assign StallExecute   = w_mem_stall;
  assign StallMemory    = w_mem_stall;
  assign FlushDecode    = w_flush_decode;
  assign FlushExecute   = !w_mem_stall && (PCSrcE || w_load_use);
  assign FlushWriteback = w_mem_stall;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_WIDTH-1:0] r_load_use_cnt;
  logic [PERF_CNT_WIDTH-1:0] r_mem_stall_cnt;
  logic [PERF_CNT_WIDTH-1:0] r_flush_cnt;

  // Saturating counters: they stop at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_use_cnt  <= '0;
      r_mem_stall_cnt <= '0;
      r_flush_cnt     <= '0;
    end else begin
      if (w_load_use && !w_mem_stall && !(&r_load_use_cnt))
        r_load_use_cnt <= r_load_use_cnt + PERF_CNT_WIDTH'(1);
      if (w_mem_stall && !(&r_mem_stall_cnt))
        r_mem_stall_cnt <= r_mem_stall_cnt + PERF_CNT_WIDTH'(1);
      if (w_flush_decode && !(&r_flush_cnt))
        r_flush_cnt <= r_flush_cnt + PERF_CNT_WIDTH'(1);
    end
  end

  assign LoadUseCnt  = r_load_use_cnt;
  assign MemStallCnt = r_mem_stall_cnt;
  assign FlushCnt    = r_flush_cnt;
`else
  assign LoadUseCnt  = '0;
  assign MemStallCnt = '0;
  assign FlushCnt    = '0;
`endif

endmodule
